// File: rtl/gshare_bht.sv
// Gshare branch direction predictor: a PC-xor-history indexed table of saturating
// counters, a speculative global history register with mispredict restore, and an init sweep.
module gshare_bht #(
   parameter int NUM_ENTRIES = 16,
   parameter int ADDR_WIDTH  = 32,
   parameter int CTR_WIDTH   = 2,
   parameter int HIST_LEN    = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   output logic                      READY,
   input  logic                      PRED_EN,
   input  logic [ADDR_WIDTH-1:0]     PC_IN_PRED,
   input  logic [ADDR_WIDTH-1:0]     SKIP_OFF_IN,
   input  logic [ADDR_WIDTH-1:0]     TAKE_OFF_IN,
   output logic [ADDR_WIDTH-1:0]     TAKE_OUT,
   output logic                      PRED_TAKEN,
   output logic [HIST_LEN-1:0]       PRED_HIST,
   input  logic                      WE,
   input  logic [ADDR_WIDTH-1:0]     PC_IN_RES,
   input  logic [HIST_LEN-1:0]       RES_HIST,
   input  logic                      TAKE_IN,
   input  logic                      MISPRED,
   output logic [15:0]               MISPRED_CNT,
   output logic                      DBG_STATE,
   output logic [$clog2(NUM_ENTRIES)-1:0] DBG_PTR
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
   localparam logic [CTR_WIDTH-1:0] CTR_ZERO = '0;
   localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_MAX >> 1;
   localparam logic [IDX_W-1:0]     PTR_LAST = IDX_W'(NUM_ENTRIES - 1);

   // Handshake: PRED_EN and WE are single-cycle strobes; each is accepted on the
   // rising edge where it is high and READY is high, and is dropped otherwise.

   logic [0:0]           state;
   logic [IDX_W-1:0]     ptr;
   logic [HIST_LEN-1:0]  ghr;
   logic [15:0]          mispred_cnt;
   logic [CTR_WIDTH-1:0] ctr_tbl [NUM_ENTRIES];

   logic                 ready;
   logic [IDX_W-1:0]     pred_idx;
   logic [CTR_WIDTH-1:0] pred_ctr;
   logic                 pred_taken;
   logic [IDX_W-1:0]     upd_idx;
   logic [CTR_WIDTH-1:0] upd_ctr;
   logic [CTR_WIDTH-1:0] upd_next;
   logic                 upd_fire;
   logic                 restore_fire;
   logic                 shift_fire;
   logic                 unused_pc_bits;

   assign ready        = (state == ST_RUN);
   assign upd_fire     = WE & ready;
   assign restore_fire = WE & MISPRED & ready;
   assign shift_fire   = PRED_EN & ready;

   assign unused_pc_bits = ^{PC_IN_RES[ADDR_WIDTH-1:IDX_W]};

   // Prediction path is purely combinational off the pre-edge table contents.
   assign pred_idx   = PC_IN_PRED[IDX_W-1:0] ^ IDX_W'(ghr);
   assign pred_ctr   = ctr_tbl[pred_idx];
   assign pred_taken = ready & pred_ctr[CTR_WIDTH-1];

   assign upd_idx = PC_IN_RES[IDX_W-1:0] ^ IDX_W'(RES_HIST);
   assign upd_ctr = ctr_tbl[upd_idx];

   always_comb begin
      upd_next = upd_ctr;
      if (TAKE_IN) begin
         if (upd_ctr != CTR_MAX) upd_next = upd_ctr + CTR_WIDTH'(1);
      end else begin
         if (upd_ctr != CTR_ZERO) upd_next = upd_ctr - CTR_WIDTH'(1);
      end
   end

   // Table storage has no reset; the INIT sweep is what makes it defined.
   always_ff @(posedge CLK) begin
      if (state == ST_INIT) begin
         ctr_tbl[ptr] <= CTR_INIT;
      end else if (upd_fire) begin
         ctr_tbl[upd_idx] <= upd_next;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_INIT;
         ptr   <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               if (ptr == PTR_LAST) begin
                  state <= ST_RUN;
                  ptr   <= '0;
               end else begin
                  ptr <= ptr + IDX_W'(1);
               end
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   // A restore wins over the speculative shift issued in the same cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ghr <= '0;
      end else if (restore_fire) begin
         ghr <= {RES_HIST[HIST_LEN-2:0], TAKE_IN};
      end else if (shift_fire) begin
         ghr <= {ghr[HIST_LEN-2:0], pred_taken};
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mispred_cnt <= '0;
      end else if (restore_fire && (mispred_cnt != 16'hFFFF)) begin
         mispred_cnt <= mispred_cnt + 16'd1;
      end
   end

   assign READY       = ready;
   assign PRED_TAKEN  = pred_taken;
   assign TAKE_OUT    = PC_IN_PRED + (pred_taken ? TAKE_OFF_IN : SKIP_OFF_IN);
   assign PRED_HIST   = ghr;
   assign MISPRED_CNT = mispred_cnt;
   assign DBG_STATE   = state[0];
   assign DBG_PTR     = ptr;

endmodule

// File: tb/tb_gshare_bht.sv
// Bench for gshare_bht: directed vectors, a behavioural predictor model checked on
// every falling edge, and literal expectations for the key scenarios.
module tb_gshare_bht;

   localparam int NE = 16;
   localparam int AW = 32;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          READY;
   logic          PRED_EN = 1'b0;
   logic [AW-1:0] PC_IN_PRED = '0;
   logic [AW-1:0] SKIP_OFF_IN = '0;
   logic [AW-1:0] TAKE_OFF_IN = '0;
   logic [AW-1:0] TAKE_OUT;
   logic          PRED_TAKEN;
   logic [3:0]    PRED_HIST;
   logic          WE = 1'b0;
   logic [AW-1:0] PC_IN_RES = '0;
   logic [3:0]    RES_HIST = '0;
   logic          TAKE_IN = 1'b0;
   logic          MISPRED = 1'b0;
   logic [15:0]   MISPRED_CNT;
   logic          DBG_STATE;
   logic [3:0]    DBG_PTR;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: counters as plain ints, history as an int, init as a countdown.
   int m_tbl [NE];
   int m_ghr       = 0;
   int m_cnt       = 0;
   int m_init_left = NE;
   bit m_ready     = 1'b0;

   gshare_bht #(
      .NUM_ENTRIES(NE), .ADDR_WIDTH(AW), .CTR_WIDTH(2), .HIST_LEN(4)
   ) dut (
      .CLK(CLK), .RST(RST), .READY(READY), .PRED_EN(PRED_EN),
      .PC_IN_PRED(PC_IN_PRED), .SKIP_OFF_IN(SKIP_OFF_IN), .TAKE_OFF_IN(TAKE_OFF_IN),
      .TAKE_OUT(TAKE_OUT), .PRED_TAKEN(PRED_TAKEN), .PRED_HIST(PRED_HIST),
      .WE(WE), .PC_IN_RES(PC_IN_RES), .RES_HIST(RES_HIST), .TAKE_IN(TAKE_IN),
      .MISPRED(MISPRED), .MISPRED_CNT(MISPRED_CNT),
      .DBG_STATE(DBG_STATE), .DBG_PTR(DBG_PTR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_ready     = 1'b0;
         m_init_left = NE;
         m_ghr       = 0;
         m_cnt       = 0;
      end else if (!m_ready) begin
         m_tbl[NE - m_init_left] = 1;
         m_init_left--;
         if (m_init_left == 0) m_ready = 1'b1;
      end else begin
         int  pi, ui;
         bit  pt;
         pi = int'(PC_IN_PRED[3:0]) ^ m_ghr;
         pt = (m_tbl[pi] >= 2);
         if (WE) begin
            ui = int'(PC_IN_RES[3:0]) ^ int'(RES_HIST);
            if (TAKE_IN) m_tbl[ui] = (m_tbl[ui] == 3) ? 3 : m_tbl[ui] + 1;
            else         m_tbl[ui] = (m_tbl[ui] == 0) ? 0 : m_tbl[ui] - 1;
         end
         if (WE && MISPRED) begin
            m_ghr = ((int'(RES_HIST) << 1) | int'(TAKE_IN)) & 15;
            m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
         end else if (PRED_EN) begin
            m_ghr = ((m_ghr << 1) | int'(pt)) & 15;
         end
      end
   end

   always @(negedge CLK) begin
      if (!RST) begin
         logic [31:0] exp_out;
         bit          exp_pt;
         exp_pt  = m_ready && (m_tbl[int'(PC_IN_PRED[3:0]) ^ m_ghr] >= 2);
         exp_out = PC_IN_PRED + (exp_pt ? TAKE_OFF_IN : SKIP_OFF_IN);
         check("cmp_ready", 32'(READY), 32'(m_ready));
         check("cmp_state", 32'(DBG_STATE), 32'(m_ready));
         check("cmp_pred_taken", 32'(PRED_TAKEN), 32'(exp_pt));
         check("cmp_take_out", TAKE_OUT, exp_out);
         check("cmp_pred_hist", 32'(PRED_HIST), 32'(m_ghr));
         check("cmp_mispred_cnt", 32'(MISPRED_CNT), 32'(m_cnt));
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!READY && n < 40);
   endtask

   task automatic resolve(input logic [31:0] pc, input logic [3:0] h, input bit t, input bit mp);
      PC_IN_RES = pc;
      RES_HIST  = h;
      TAKE_IN   = t;
      MISPRED   = mp;
      WE        = 1'b1;
      step();
      WE      = 1'b0;
      MISPRED = 1'b0;
      #1;
   endtask

   task automatic predict(input logic [31:0] pc);
      PC_IN_PRED = pc;
      #1;
      check("req020_taken_entry", 32'(PRED_TAKEN), 32'd1);
      PRED_EN = 1'b1;
      step();
      PRED_EN = 1'b0;
      #1;
   endtask

   initial begin
      int n;
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      PC_IN_PRED  = 32'h100;
      SKIP_OFF_IN = 32'h4;
      TAKE_OFF_IN = 32'h40;
      #1 RST = 1'b1;
      PRED_EN = 1'b1;
      WE      = 1'b1;
      MISPRED = 1'b1;
      TAKE_IN = 1'b1;
      repeat (3) step();
      check("rst_ready", 32'(READY), 32'd0);
      check("rst_cnt", 32'(MISPRED_CNT), 32'd0);
      check("rst_hist", 32'(PRED_HIST), 32'd0);
      check("rst_ptr", 32'(DBG_PTR), 32'd0);
      check("rst_take_out", TAKE_OUT, 32'h104);

      // Release with PRED_EN and a mispredict resolve held: both must be ignored.
      RST = 1'b0;
      wait_ready(n);
      PRED_EN = 1'b0;
      WE      = 1'b0;
      MISPRED = 1'b0;
      check("init_len", 32'(n), 32'd16);
      check("init_hist", 32'(PRED_HIST), 32'd0);
      check("init_cnt", 32'(MISPRED_CNT), 32'd0);

      #1;
      check("req019_pt0", 32'(PRED_TAKEN), 32'd0);
      check("req019_out0", TAKE_OUT, 32'h104);
      resolve(32'h100, 4'h0, 1'b1, 1'b0);
      check("req019_pt1", 32'(PRED_TAKEN), 32'd1);
      check("req019_out1", TAKE_OUT, 32'h140);
      resolve(32'h100, 4'h0, 1'b1, 1'b0);
      resolve(32'h100, 4'h0, 1'b1, 1'b0);
      resolve(32'h100, 4'h0, 1'b0, 1'b0);
      check("req019_sat_pt", 32'(PRED_TAKEN), 32'd1);
      resolve(32'h100, 4'h0, 1'b0, 1'b0);
      check("req019_back_pt", 32'(PRED_TAKEN), 32'd0);

      resolve(32'h5, 4'h0, 1'b1, 1'b0);
      resolve(32'h5, 4'h0, 1'b1, 1'b0);
      predict(32'h5);
      predict(32'h4);
      predict(32'h6);
      check("req020_hist", 32'(PRED_HIST), 32'h7);
      PC_IN_PRED = 32'h7;
      PRED_EN    = 1'b1;
      resolve(32'h6, 4'b0011, 1'b0, 1'b1);
      PRED_EN = 1'b0;
      check("req020_restore", 32'(PRED_HIST), 32'h6);
      check("req020_cnt", 32'(MISPRED_CNT), 32'd1);

      MISPRED = 1'b1;
      step();
      MISPRED = 1'b0;
      #1;
      check("req012_hist", 32'(PRED_HIST), 32'h6);
      check("req012_cnt", 32'(MISPRED_CNT), 32'd1);

      resolve(32'h2, 4'b0010, 1'b1, 1'b1);
      check("req021_hist", 32'(PRED_HIST), 32'h5);
      PC_IN_PRED = 32'h3;
      PC_IN_RES  = 32'h3;
      RES_HIST   = 4'h5;
      TAKE_IN    = 1'b1;
      WE         = 1'b1;
      #1;
      check("req021_old_pt", 32'(PRED_TAKEN), 32'd0);
      check("req021_old_out", TAKE_OUT, 32'h7);
      step();
      WE = 1'b0;
      #1;
      check("req021_new_pt", 32'(PRED_TAKEN), 32'd1);
      check("req021_new_out", TAKE_OUT, 32'h43);

      // Mixed traffic with a wrapping taken offset; the model checks every cycle.
      SKIP_OFF_IN = 32'h8;
      TAKE_OFF_IN = 32'hFFFF_FFF0;
      for (int i = 0; i < 32; i++) begin
         PRED_EN    = (i % 2) == 1;
         WE         = (i % 3) == 0;
         MISPRED    = (i % 4) == 1;
         PC_IN_PRED = 32'(i * 5);
         PC_IN_RES  = 32'(i * 3);
         RES_HIST   = 4'(i);
         TAKE_IN    = (i % 7) < 4;
         step();
      end
      PRED_EN = 1'b0;
      WE      = 1'b0;
      MISPRED = 1'b0;
      SKIP_OFF_IN = 32'h4;
      TAKE_OFF_IN = 32'h40;

      // Fresh reset, then build a count of exactly five mispredicts.
      #1 RST = 1'b1;
      step();
      RST = 1'b0;
      wait_ready(n);
      check("reinit_len", 32'(n), 32'd16);
      for (int k = 0; k < 5; k++) resolve(32'h0, 4'h0, 1'b1, 1'b1);
      check("req022_cnt5", 32'(MISPRED_CNT), 32'd5);
      RST = 1'b1;
      #1;
      check("req022_async_ready", 32'(READY), 32'd0);
      check("req022_async_cnt", 32'(MISPRED_CNT), 32'd0);
      check("req022_async_hist", 32'(PRED_HIST), 32'd0);
      check("req022_async_ptr", 32'(DBG_PTR), 32'd0);
      step();
      RST = 1'b0;
      repeat (7) step();
      check("req022_ptr7", 32'(DBG_PTR), 32'd7);
      check("req022_mid_ready", 32'(READY), 32'd0);
      #1 RST = 1'b1;
      #1;
      check("req022_mid_ptr", 32'(DBG_PTR), 32'd0);
      check("req022_mid_state", 32'(DBG_STATE), 32'd0);
      step();
      RST = 1'b0;
      wait_ready(n);
      check("req022_len", 32'(n), 32'd16);

      // Every entry must hold the weak not-taken value: not taken, then taken after one hit.
      for (int i = 0; i < NE; i++) begin
         PC_IN_PRED = 32'(i);
         #1;
         check("sweep_pt_before", 32'(PRED_TAKEN), 32'd0);
         resolve(32'(i), 4'h0, 1'b1, 1'b0);
         check("sweep_pt_after", 32'(PRED_TAKEN), 32'd1);
      end

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
